// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: next-PC select, fetch FSM states and instruction fields.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_UPD   = 3'd4,
        S_FAULT = 3'd5
    } fetch_state_t;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int JIDX_HI   = 25;
    localparam int JIDX_LO   = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Branch immediates are word offsets; sign-extend and scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target selection for the fetch unit, plus the misaligned-jr indication.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [1:0]                 redirect_sel,
    input  logic [31:0]                pc4_in,
    input  logic [15:0]                branch_imm16,
    input  logic [JIDX_HI:JIDX_LO]     jump_index,
    input  logic [31:0]                jr_target,
    output logic [31:0]                target,
    output logic                       jr_misalign
);

    always_comb begin
        target = pc4_in;
        case (redirect_sel)
            NPC_SEQ: target = pc4_in;
            NPC_BR:  target = pc4_in + branch_offset(branch_imm16);
            NPC_J:   target = {pc4_in[31:28], jump_index, 2'b00};
            NPC_JR:  target = jr_target;
            default: target = pc4_in;
        endcase
    end

    assign jr_misalign = (redirect_sel == NPC_JR) && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: fetches the word at pc_in over req/ack, holds it in the IR for decode,
// then writes the selected next PC back to the PC register.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] pc_next,
    output logic        pc_wre,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic [1:0]  redirect_sel,
    input  logic [15:0] branch_imm16,
    input  logic [31:0] jr_target,
    output logic        fault
);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       target;
    logic              jr_misalign;
    logic              ack_seen;
    logic              latch_ir;
    logic              take_pc;
    logic              misalign_ahead;
    logic              req_d;

    next_pc_calc u_next_pc (
        .redirect_sel (redirect_sel),
        .pc4_in       (pc4_in),
        .branch_imm16 (branch_imm16),
        .jump_index   (ir_out[JIDX_HI:JIDX_LO]),
        .jr_target    (jr_target),
        .target       (target),
        .jr_misalign  (jr_misalign)
    );

    assign ack_seen  = imem_req && imem_ack;
    assign imem_addr = imem_req ? pc_in : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        latch_ir   = 1'b0;
        take_pc    = 1'b0;
        case (state)
            S_IDLE: next_state = S_REQ;
            S_REQ: begin
                if (pc_in[1:0] != 2'b00) begin
                    next_state = S_FAULT;
                end else if (ack_seen) begin
                    next_state = S_HOLD;
                    latch_ir   = 1'b1;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_seen) begin
                    next_state = S_HOLD;
                    latch_ir   = 1'b1;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    next_state = S_FAULT;
                end
            end
            S_HOLD: begin
                if (ir_ready) begin
                    if (jr_misalign) begin
                        next_state = S_FAULT;
                    end else begin
                        next_state = S_UPD;
                        take_pc    = 1'b1;
                    end
                end
            end
            S_UPD:   next_state = S_REQ;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_IDLE;
        endcase
    end

    // imem_req is registered, so the alignment of the PC that REQ will see is judged one cycle early:
    // leaving UPD that PC is the pc_next being written, otherwise it is the current pc_in.
    always_comb begin
        misalign_ahead = (state == S_UPD) ? (pc_next[1:0] != 2'b00) : (pc_in[1:0] != 2'b00);
        req_d = (next_state == S_WAIT) || ((next_state == S_REQ) && !misalign_ahead);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_req <= 1'b0;
            ir_out   <= 32'h0;
            ir_valid <= 1'b0;
            pc_wre   <= 1'b0;
            pc_next  <= 32'h0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            imem_req <= req_d;
            ir_valid <= (next_state == S_HOLD);
            pc_wre   <= (next_state == S_UPD);
            fault    <= (next_state == S_FAULT);
            if (latch_ir) ir_out  <= imem_rdata;
            if (take_pc)  pc_next <= target;
            if (state == S_REQ && next_state == S_WAIT)
                wait_cnt <= WAIT_W'(1);
            else if (state == S_WAIT && next_state == S_WAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; expected IR words and next-PC values go through scoreboard queues.
module tb_ifetch_unit;
    import mips_pkg::*;

    localparam int MAX_WAIT = 15;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic [31:0] pc_in        = 32'h0;
    logic [31:0] pc4_in       = 32'h4;
    logic [31:0] pc_next;
    logic        pc_wre;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack     = 1'b0;
    logic [31:0] imem_rdata   = 32'h0;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ready     = 1'b0;
    logic [1:0]  redirect_sel = NPC_SEQ;
    logic [15:0] branch_imm16 = 16'h0;
    logic [31:0] jr_target    = 32'h0;
    logic        fault;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ir_q[$];
    logic [31:0] exp_pc_q[$];

    ifetch_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc4_in       (pc4_in),
        .pc_next      (pc_next),
        .pc_wre       (pc_wre),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .redirect_sel (redirect_sel),
        .branch_imm16 (branch_imm16),
        .jr_target    (jr_target),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput("req_valid_exclusive", 32'(imem_req & ir_valid), 32'h0);
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] pc4, input logic [1:0] sel,
                                 input logic [15:0] imm, input logic [31:0] jrt);
        pc_in        = pc;
        pc4_in       = pc4;
        redirect_sel = sel;
        branch_imm16 = imm;
        jr_target    = jrt;
    endtask

    task automatic checkReset();
        checkOutput("rst_imem_req",  32'(imem_req), 32'h0);
        checkOutput("rst_imem_addr", imem_addr,     32'h0);
        checkOutput("rst_ir_out",    ir_out,        32'h0);
        checkOutput("rst_ir_valid",  32'(ir_valid), 32'h0);
        checkOutput("rst_pc_wre",    32'(pc_wre),   32'h0);
        checkOutput("rst_pc_next",   pc_next,       32'h0);
        checkOutput("rst_fault",     32'(fault),    32'h0);
    endtask

    task automatic doReset();
        reset    = 1'b0;
        imem_ack = 1'b0;
        ir_ready = 1'b0;
        exp_ir_q.delete();
        exp_pc_q.delete();
        step();
        checkReset();
        reset = 1'b1;
    endtask

    task automatic waitForReq();
        int n = 0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        checkOutput("req_seen", 32'(imem_req), 32'h1);
    endtask

    task automatic fetch(input logic [31:0] rdata, input int delay);
        logic [31:0] addr0;
        waitForReq();
        addr0 = imem_addr;
        checkOutput("imem_addr", imem_addr, pc_in);
        for (int i = 0; i < delay; i++) begin
            step();
            checkOutput("req_stable", 32'(imem_req), 32'h1);
            checkOutput("addr_stable", imem_addr, addr0);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_ir_q.push_back(rdata);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0BAD0;
        checkOutput("ir_valid", 32'(ir_valid), 32'h1);
        checkOutput("req_drop", 32'(imem_req), 32'h0);
        if (exp_ir_q.size() > 0) checkOutput("ir_out", ir_out, exp_ir_q.pop_front());
    endtask

    // Offer ready for one HOLD cycle; on success the bench's PC register captures the expected next PC.
    task automatic accept(input logic [1:0] sel, input logic [15:0] imm, input logic [31:0] jrt,
                          input logic [31:0] exp_pc, input bit exp_fault);
        checkOutput("no_wre_in_hold", 32'(pc_wre), 32'h0);
        redirect_sel = sel;
        branch_imm16 = imm;
        jr_target    = jrt;
        ir_ready     = 1'b1;
        if (!exp_fault) exp_pc_q.push_back(exp_pc);
        step();
        ir_ready = 1'b0;
        checkOutput("ir_valid_clear", 32'(ir_valid), 32'h0);
        if (exp_fault) begin
            checkOutput("fault_set", 32'(fault), 32'h1);
            checkOutput("no_wre_on_fault", 32'(pc_wre), 32'h0);
        end else begin
            checkOutput("pc_wre_pulse", 32'(pc_wre), 32'h1);
            if (exp_pc_q.size() > 0) checkOutput("pc_next", pc_next, exp_pc_q.pop_front());
            pc_in  = exp_pc;
            pc4_in = exp_pc + 32'd4;
            step();
            checkOutput("pc_wre_single", 32'(pc_wre), 32'h0);
            checkOutput("req_after_upd", 32'(imem_req), 32'h1);
        end
    endtask

    initial begin
        int          cnt;
        int          wre_cnt;
        bit          bad;
        logic [31:0] held;

        $display("[TB] start");

        // 1: zero-wait fetch, sequential next PC
        applyStimulus(32'h0, 32'h4, NPC_SEQ, 16'h0, 32'h0);
        doReset();
        fetch(32'h2001000A, 0);
        accept(NPC_SEQ, 16'h0, 32'h0, 32'h00000004, 1'b0);

        // 2: branch backwards, then branch wrapping past 2^32
        fetch(32'h1000FFFE, 0);
        pc4_in = 32'h104;
        accept(NPC_BR, 16'hFFFE, 32'h0, 32'h000000FC, 1'b0);
        fetch(32'h10000001, 0);
        pc4_in = 32'hFFFFFFFC;
        accept(NPC_BR, 16'h0001, 32'h0, 32'h00000000, 1'b0);

        // 3: jump, then misaligned jr faults without a PC write
        fetch(32'h08000040, 0);
        pc4_in = 32'h40000008;
        accept(NPC_J, 16'h0, 32'h0, 32'h40000100, 1'b0);
        fetch(32'h03E00008, 0);
        accept(NPC_JR, 16'h0, 32'h00001002, 32'h0, 1'b1);
        wre_cnt = 0;
        bad     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            wre_cnt += int'(pc_wre);
            if (!fault || imem_req || ir_valid) bad = 1'b1;
        end
        checkOutput("jr_fault_no_wre", 32'(wre_cnt), 32'h0);
        checkOutput("jr_fault_sticky", 32'(bad), 32'h0);

        // 4: ack after 5 wait cycles, then a fetch that times out
        applyStimulus(32'h100, 32'h104, NPC_SEQ, 16'h0, 32'h0);
        doReset();
        fetch(32'h8C220004, 5);
        accept(NPC_SEQ, 16'h0, 32'h0, 32'h00000104, 1'b0);
        cnt = 0;
        while (imem_req && cnt < 40) begin
            cnt++;
            step();
        end
        checkOutput("timeout_cycles", 32'(cnt), 32'(MAX_WAIT + 1));
        checkOutput("timeout_fault", 32'(fault), 32'h1);
        checkOutput("timeout_req_low", 32'(imem_req), 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        step();
        imem_ack = 1'b0;
        checkOutput("ack_ignored_ir", ir_out, 32'h8C220004);
        checkOutput("ack_ignored_valid", 32'(ir_valid), 32'h0);

        // 5: decode stalls for 10 cycles, then accepts once
        applyStimulus(32'h200, 32'h204, NPC_SEQ, 16'h0, 32'h0);
        doReset();
        fetch(32'h00221820, 0);
        held    = 32'h00221820;
        wre_cnt = 0;
        bad     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            wre_cnt += int'(pc_wre);
            if (!ir_valid || ir_out !== held) bad = 1'b1;
        end
        checkOutput("stall_hold_stable", 32'(bad), 32'h0);
        checkOutput("stall_no_wre", 32'(wre_cnt), 32'h0);
        accept(NPC_SEQ, 16'h0, 32'h0, 32'h00000204, 1'b0);

        // Misaligned PC out of reset: fault with no request
        applyStimulus(32'h2, 32'h6, NPC_SEQ, 16'h0, 32'h0);
        doReset();
        step();
        checkOutput("misalign_no_req", 32'(imem_req), 32'h0);
        checkOutput("misalign_no_addr", imem_addr, 32'h0);
        step();
        checkOutput("misalign_fault", 32'(fault), 32'h1);

        // 6: reset mid-WAIT with a late ack, then reset mid-HOLD
        applyStimulus(32'h300, 32'h304, NPC_SEQ, 16'h0, 32'h0);
        doReset();
        waitForReq();
        for (int i = 0; i < 3; i++) step();
        checkOutput("in_wait_req", 32'(imem_req), 32'h1);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        checkReset();
        reset = 1'b1;
        step();
        imem_ack = 1'b0;
        checkOutput("late_ack_ir", ir_out, 32'h0);
        checkOutput("late_ack_valid", 32'(ir_valid), 32'h0);
        fetch(32'h12345678, 0);
        reset = 1'b0;
        step();
        checkReset();
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
